// File: rtl/arm_pipelined_pkg.sv
// Shared constants and types for the ARM pipelined fetch/decode front end.
package arm_pipelined_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } fetch_state_t;

   // Instruction field bit positions
   localparam int unsigned COND_MSB  = 31;
   localparam int unsigned COND_LSB  = 28;
   localparam int unsigned OP_MSB    = 27;
   localparam int unsigned OP_LSB    = 26;
   localparam int unsigned FUNCT_MSB = 25;
   localparam int unsigned FUNCT_LSB = 20;
   localparam int unsigned RD_MSB    = 15;
   localparam int unsigned RD_LSB    = 12;

   localparam int unsigned PC_INCR        = 4;
   localparam int unsigned PC_READ_OFFSET = 8;

endpackage

// File: rtl/arm_pipelined_fetch_skid_buffer.sv
// One-entry instruction+PC holding buffer used while decode is stalled.
module arm_pipelined_fetch_skid_buffer #(
   parameter int unsigned BusWidth = 32
) (
   input  logic                i_CLK,
   input  logic                i_NRESET,
   input  logic                clear,
   input  logic                push,
   input  logic                pop,
   input  logic [BusWidth-1:0] wr_instr,
   input  logic [BusWidth-1:0] wr_pc,
   output logic                full,
   output logic [BusWidth-1:0] rd_instr,
   output logic [BusWidth-1:0] rd_pc
);

   // Clear wins; a push (also a refill while popping) keeps it full; a lone pop empties it
   always_ff @(posedge i_CLK or negedge i_NRESET) begin
      if (!i_NRESET) begin
         full     <= 1'b0;
         rd_instr <= '0;
         rd_pc    <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (push) begin
         full     <= 1'b1;
         rd_instr <= wr_instr;
         rd_pc    <= wr_pc;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/arm_pipelined_fetch_stage.sv
// Fetch stage + IF/ID register: PC, req/ack instruction-memory handshake,
// one-word skid buffer, redirects, stalls and flushes.
// Optional macro ARM_FETCH_PERF_CNT_EN adds saturating perf counters.
module arm_pipelined_fetch_stage
   import arm_pipelined_pkg::*;
#(
   parameter int unsigned         BusWidth    = 32,
   parameter logic [BusWidth-1:0] ResetVector = '0
) (
   input  logic                i_CLK,
   input  logic                i_NRESET,
   input  logic                i_SCLR,
   input  logic                i_Stall_Fetch,
   input  logic                i_Stall_Decode,
   input  logic                i_Flush_Decode,
   input  logic                i_Branch_Taken_Execute,
   input  logic [BusWidth-1:0] i_ALU_Result_Execute,
   input  logic                i_PC_Src_WriteBack,
   input  logic [BusWidth-1:0] i_Result_WriteBack,
   output logic                o_IMem_Req,
   output logic [BusWidth-1:0] o_IMem_Addr,
   input  logic                i_IMem_Ack,
   input  logic [BusWidth-1:0] i_IMem_RData,
   output logic [BusWidth-1:0] o_Instr_Decode,
   output logic [3:0]          o_Cond_Decode,
   output logic [1:0]          o_Op_Decode,
   output logic [5:0]          o_Funct_Decode,
   output logic [3:0]          o_Rd_Decode,
   output logic [BusWidth-1:0] o_PC_Plus_8_Decode,
   output logic                o_Valid_Decode
`ifdef ARM_FETCH_PERF_CNT_EN
   ,
   output logic [31:0]         o_Perf_Fetched,
   output logic [31:0]         o_Perf_Bubbles
`endif
);

   localparam logic [BusWidth-1:0] NOP_WORD = BusWidth'(NOP_INSTR);
   localparam logic [BusWidth-1:0] PC_STEP  = BusWidth'(PC_INCR);
   localparam logic [BusWidth-1:0] PC_OFS   = BusWidth'(PC_READ_OFFSET);

   fetch_state_t        state_q, state_d;
   logic [BusWidth-1:0] pc_f_q, addr_q, fetch_addr, target;
   logic                redirect, accept, latch_addr;
   logic                buf_full, buf_push, buf_pop, buf_room;
   logic [BusWidth-1:0] buf_instr, buf_pc;

   // Redirect selection, buffer drain/room and the aligned fetch address
   always_comb begin
      redirect   = i_Branch_Taken_Execute | i_PC_Src_WriteBack;
      target     = i_Branch_Taken_Execute ? i_ALU_Result_Execute : i_Result_WriteBack;
      buf_pop    = buf_full & ~i_Flush_Decode & ~redirect & ~i_Stall_Decode;
      buf_room   = ~buf_full | buf_pop;
      fetch_addr = {pc_f_q[BusWidth-1:2], 2'b00};
      buf_push   = accept & ~i_Flush_Decode & (i_Stall_Decode | buf_full);
   end

   // Handshake next-state and request outputs
   always_comb begin
      state_d     = state_q;
      o_IMem_Req  = 1'b0;
      o_IMem_Addr = fetch_addr;
      accept      = 1'b0;
      latch_addr  = 1'b0;
      case (state_q)
         S_IDLE: begin
            o_IMem_Req = i_NRESET & ~i_Stall_Fetch & ~redirect & buf_room;
            if (o_IMem_Req) begin
               if (i_IMem_Ack) begin
                  accept = 1'b1;
               end else begin
                  latch_addr = 1'b1;
                  state_d    = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            o_IMem_Req  = 1'b1;
            o_IMem_Addr = addr_q;
            if (i_IMem_Ack) begin
               accept  = ~redirect;
               state_d = S_IDLE;
            end else if (redirect) begin
               state_d = S_DISCARD;
            end
         end
         S_DISCARD: begin
            o_IMem_Req  = 1'b1;
            o_IMem_Addr = addr_q;
            if (i_IMem_Ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; SCLR must let an outstanding (or just issued) request finish in DISCARD
   always_ff @(posedge i_CLK or negedge i_NRESET) begin
      if (!i_NRESET)   state_q <= S_IDLE;
      else if (i_SCLR) state_q <= (state_d == S_IDLE) ? S_IDLE : S_DISCARD;
      else             state_q <= state_d;
   end

   // Outstanding request address, kept stable through WAIT/DISCARD
   always_ff @(posedge i_CLK or negedge i_NRESET) begin
      if (!i_NRESET)       addr_q <= '0;
      else if (latch_addr) addr_q <= fetch_addr;
   end

   // Program counter: redirect target, else advance on an accepted word
   always_ff @(posedge i_CLK or negedge i_NRESET) begin
      if (!i_NRESET)     pc_f_q <= ResetVector;
      else if (i_SCLR)   pc_f_q <= ResetVector;
      else if (redirect) pc_f_q <= target;
      else if (accept)   pc_f_q <= pc_f_q + PC_STEP;
   end

   arm_pipelined_fetch_skid_buffer #(.BusWidth(BusWidth)) u_skid (
      .i_CLK    (i_CLK),
      .i_NRESET (i_NRESET),
      .clear    (redirect | i_SCLR),
      .push     (buf_push),
      .pop      (buf_pop),
      .wr_instr (i_IMem_RData),
      .wr_pc    (pc_f_q),
      .full     (buf_full),
      .rd_instr (buf_instr),
      .rd_pc    (buf_pc)
   );

   // IF/ID register: flush/redirect bubble > stall hold > buffered word > new word > bubble
   always_ff @(posedge i_CLK or negedge i_NRESET) begin
      if (!i_NRESET || i_SCLR) begin
         o_Instr_Decode     <= NOP_WORD;
         o_Valid_Decode     <= 1'b0;
         o_PC_Plus_8_Decode <= ResetVector + PC_OFS;
      end else if (i_Flush_Decode || redirect) begin
         o_Instr_Decode <= NOP_WORD;
         o_Valid_Decode <= 1'b0;
      end else if (!i_Stall_Decode) begin
         if (buf_full) begin
            o_Instr_Decode     <= buf_instr;
            o_Valid_Decode     <= 1'b1;
            o_PC_Plus_8_Decode <= buf_pc + PC_OFS;
         end else if (accept) begin
            o_Instr_Decode     <= i_IMem_RData;
            o_Valid_Decode     <= 1'b1;
            o_PC_Plus_8_Decode <= pc_f_q + PC_OFS;
         end else begin
            o_Instr_Decode <= NOP_WORD;
            o_Valid_Decode <= 1'b0;
         end
      end
   end

   assign o_Cond_Decode  = o_Instr_Decode[COND_MSB:COND_LSB];
   assign o_Op_Decode    = o_Instr_Decode[OP_MSB:OP_LSB];
   assign o_Funct_Decode = o_Instr_Decode[FUNCT_MSB:FUNCT_LSB];
   assign o_Rd_Decode    = o_Instr_Decode[RD_MSB:RD_LSB];

`ifdef ARM_FETCH_PERF_CNT_EN
   logic idle_bubble;
   assign idle_bubble = ~i_Flush_Decode & ~redirect & ~i_Stall_Decode & ~buf_full & ~accept;

   // Saturating counters of accepted words and idle bubbles loaded into IF/ID
   always_ff @(posedge i_CLK or negedge i_NRESET) begin
      if (!i_NRESET || i_SCLR) begin
         o_Perf_Fetched <= '0;
         o_Perf_Bubbles <= '0;
      end else begin
         if (accept && o_Perf_Fetched != '1)      o_Perf_Fetched <= o_Perf_Fetched + 32'd1;
         if (idle_bubble && o_Perf_Bubbles != '1) o_Perf_Bubbles <= o_Perf_Bubbles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_arm_pipelined_fetch_stage.sv
// Self-checking bench for arm_pipelined_fetch_stage: scoreboard of expected decode words.
module tb_arm_pipelined_fetch_stage;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc8;
   } sb_entry_t;

   logic        clk, rst_n, sclr;
   logic        i_Stall_Fetch, i_Stall_Decode, i_Flush_Decode;
   logic        i_Branch_Taken_Execute, i_PC_Src_WriteBack;
   logic [31:0] i_ALU_Result_Execute, i_Result_WriteBack;
   logic        o_IMem_Req, ack;
   logic [31:0] o_IMem_Addr, rdata;
   logic [31:0] o_Instr_Decode, o_PC_Plus_8_Decode;
   logic [3:0]  o_Cond_Decode, o_Rd_Decode;
   logic [1:0]  o_Op_Decode;
   logic [5:0]  o_Funct_Decode;
   logic        o_Valid_Decode;
`ifdef ARM_FETCH_PERF_CNT_EN
   logic [31:0] o_Perf_Fetched, o_Perf_Bubbles;
`endif

   int          tests = 0;
   int          fails = 0;
   sb_entry_t   sb[$];
   int unsigned lat = 0;
   logic [7:0]  cnt = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hE1A0_0000;
   endfunction

   arm_pipelined_fetch_stage #(.BusWidth(32), .ResetVector(32'h0)) dut (
      .i_CLK                  (clk),
      .i_NRESET               (rst_n),
      .i_SCLR                 (sclr),
      .i_Stall_Fetch          (i_Stall_Fetch),
      .i_Stall_Decode         (i_Stall_Decode),
      .i_Flush_Decode         (i_Flush_Decode),
      .i_Branch_Taken_Execute (i_Branch_Taken_Execute),
      .i_ALU_Result_Execute   (i_ALU_Result_Execute),
      .i_PC_Src_WriteBack     (i_PC_Src_WriteBack),
      .i_Result_WriteBack     (i_Result_WriteBack),
      .o_IMem_Req             (o_IMem_Req),
      .o_IMem_Addr            (o_IMem_Addr),
      .i_IMem_Ack             (ack),
      .i_IMem_RData           (rdata),
      .o_Instr_Decode         (o_Instr_Decode),
      .o_Cond_Decode          (o_Cond_Decode),
      .o_Op_Decode            (o_Op_Decode),
      .o_Funct_Decode         (o_Funct_Decode),
      .o_Rd_Decode            (o_Rd_Decode),
      .o_PC_Plus_8_Decode     (o_PC_Plus_8_Decode),
      .o_Valid_Decode         (o_Valid_Decode)
`ifdef ARM_FETCH_PERF_CNT_EN
      ,
      .o_Perf_Fetched         (o_Perf_Fetched),
      .o_Perf_Bubbles         (o_Perf_Bubbles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: ack once the request has been held for 'lat' cycles (lat=0 -> same cycle)
   always @(posedge clk) cnt <= (!rst_n || !o_IMem_Req || ack) ? 8'd0 : cnt + 8'd1;
   assign ack   = o_IMem_Req && (32'(cnt) >= lat);
   assign rdata = mem_word(o_IMem_Addr);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] addr, input logic [31:0] pc8);
      sb_entry_t e;
      e.instr = mem_word(addr);
      e.pc8   = pc8;
      sb.push_back(e);
   endtask

   // Pops one expected word for every new instruction that lands in IF/ID
   task automatic run_monitor();
      sb_entry_t e;
      logic      held;
      forever begin
         @(posedge clk);
         held = i_Stall_Decode;
         @(negedge clk);
         if (rst_n === 1'b1 && o_Valid_Decode === 1'b1 && !held) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL sb_unexpected: got instr=%h pc8=%h, required no valid word", o_Instr_Decode, o_PC_Plus_8_Decode);
            end else begin
               e = sb.pop_front();
               if (o_Instr_Decode !== e.instr || o_PC_Plus_8_Decode !== e.pc8 ||
                   o_Cond_Decode !== e.instr[31:28] || o_Op_Decode !== e.instr[27:26] ||
                   o_Funct_Decode !== e.instr[25:20] || o_Rd_Decode !== e.instr[15:12]) begin
                  fails++;
                  $display("FAIL sb_word: got instr=%h pc8=%h fields=%h/%h/%h/%h, required instr=%h pc8=%h",
                           o_Instr_Decode, o_PC_Plus_8_Decode, o_Cond_Decode, o_Op_Decode,
                           o_Funct_Decode, o_Rd_Decode, e.instr, e.pc8);
               end
            end
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; sclr = 1'b0; lat = 0;
      i_Stall_Fetch = 1'b1; i_Stall_Decode = 1'b0; i_Flush_Decode = 1'b0;
      i_Branch_Taken_Execute = 1'b0; i_PC_Src_WriteBack = 1'b0;
      i_ALU_Result_Execute = '0; i_Result_WriteBack = '0;
      sb.delete();
      step(); step();
      rst_n = 1'b1;
   endtask

   task automatic redirect_wb(input logic [31:0] tgt);
      i_PC_Src_WriteBack = 1'b1; i_Result_WriteBack = tgt;
      step();
      i_PC_Src_WriteBack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_Stall_Fetch = 1'b0;
      step();
      @(negedge clk);
      tests++;
      if (o_IMem_Req !== 1'b0 || o_IMem_Addr !== 32'h0 || o_Valid_Decode !== 1'b0 ||
          o_Instr_Decode !== 32'h0 || o_PC_Plus_8_Decode !== 32'h8) begin
         fails++;
         $display("FAIL reset_values: got req=%b addr=%h valid=%b instr=%h pc8=%h, required 0/0/0/0/8",
                  o_IMem_Req, o_IMem_Addr, o_Valid_Decode, o_Instr_Decode, o_PC_Plus_8_Decode);
      end
   endtask

   task automatic test_zero_wait();
      do_reset();
      for (int unsigned k = 0; k < 5; k++) push_exp(32'(4 * k), 32'(4 * k + 8));
      i_Stall_Fetch = 1'b0;
      for (int unsigned k = 0; k < 5; k++) begin
         @(negedge clk);
         tests++;
         if (o_IMem_Req !== 1'b1 || o_IMem_Addr !== 32'(4 * k)) begin
            fails++;
            $display("FAIL zw_addr%0d: got req=%b addr=%h, required req=1 addr=%h", k, o_IMem_Req, o_IMem_Addr, 32'(4 * k));
         end
         step();
      end
      i_Stall_Fetch = 1'b1;
      repeat (3) step();
      tests++;
      if (sb.size() != 0) begin fails++; $display("FAIL zw_drain: got %0d pending, required 0", sb.size()); end
   endtask

   task automatic test_wait();
      do_reset();
      redirect_wb(32'h10);
      lat = 2;
      push_exp(32'h10, 32'h18);
      i_Stall_Fetch = 1'b0;
      for (int unsigned k = 0; k < 3; k++) begin
         @(negedge clk);
         tests++;
         if (o_IMem_Req !== 1'b1 || o_IMem_Addr !== 32'h10 || o_Valid_Decode !== 1'b0) begin
            fails++;
            $display("FAIL wait_hold%0d: got req=%b addr=%h valid=%b, required 1/00000010/0", k, o_IMem_Req, o_IMem_Addr, o_Valid_Decode);
         end
         step();
      end
      i_Stall_Fetch = 1'b1;
      repeat (3) step();
      tests++;
      if (sb.size() != 0) begin fails++; $display("FAIL wait_drain: got %0d pending, required 0", sb.size()); end
   endtask

   task automatic test_branch_while_wait();
      bit found = 1'b0;
      do_reset();
      redirect_wb(32'h20);
      lat = 100; i_Stall_Fetch = 1'b0;
      step(); step();
      i_Branch_Taken_Execute = 1'b1; i_ALU_Result_Execute = 32'h100;
      @(negedge clk);
      tests++;
      if (o_IMem_Req !== 1'b1 || o_IMem_Addr !== 32'h20) begin
         fails++;
         $display("FAIL bw_hold: got req=%b addr=%h, required req=1 addr=00000020", o_IMem_Req, o_IMem_Addr);
      end
      step();
      i_Branch_Taken_Execute = 1'b0;
      push_exp(32'h100, 32'h108);
      lat = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (o_IMem_Req === 1'b1 && o_IMem_Addr !== 32'h20) found = 1'b1;
         else step();
      end
      tests++;
      if (!found || o_IMem_Addr !== 32'h100) begin
         fails++;
         $display("FAIL bw_next_addr: got found=%b addr=%h, required found=1 addr=00000100", found, o_IMem_Addr);
      end
      step();
      i_Stall_Fetch = 1'b1;
      repeat (3) step();
      tests++;
      if (sb.size() != 0) begin fails++; $display("FAIL bw_drain: got %0d pending, required 0", sb.size()); end
   endtask

   task automatic test_branch_and_wb();
      do_reset();
      i_Branch_Taken_Execute = 1'b1; i_ALU_Result_Execute = 32'h40;
      i_PC_Src_WriteBack = 1'b1;     i_Result_WriteBack   = 32'h80;
      step();
      i_Branch_Taken_Execute = 1'b0; i_PC_Src_WriteBack = 1'b0;
      push_exp(32'h40, 32'h48);
      i_Stall_Fetch = 1'b0;
      @(negedge clk);
      tests++;
      if (o_IMem_Req !== 1'b1 || o_IMem_Addr !== 32'h40) begin
         fails++;
         $display("FAIL both_redirect: got req=%b addr=%h, required req=1 addr=00000040", o_IMem_Req, o_IMem_Addr);
      end
      step();
      i_Stall_Fetch = 1'b1;
      repeat (3) step();
      tests++;
      if (sb.size() != 0) begin fails++; $display("FAIL both_drain: got %0d pending, required 0", sb.size()); end
   endtask

   task automatic test_stall_decode();
      do_reset();
      for (int unsigned k = 0; k < 5; k++) push_exp(32'(4 * k), 32'(4 * k + 8));
      i_Stall_Fetch = 1'b0;
      step();
      i_Stall_Decode = 1'b1;
      @(negedge clk);
      tests++;
      if (o_IMem_Req !== 1'b1 || o_IMem_Addr !== 32'h4) begin
         fails++;
         $display("FAIL sd_extra: got req=%b addr=%h, required req=1 addr=00000004", o_IMem_Req, o_IMem_Addr);
      end
      step();
      for (int unsigned k = 0; k < 2; k++) begin
         @(negedge clk);
         tests++;
         if (o_IMem_Req !== 1'b0 || o_Valid_Decode !== 1'b1 || o_Instr_Decode !== mem_word(32'h0)) begin
            fails++;
            $display("FAIL sd_hold%0d: got req=%b valid=%b instr=%h, required req=0 valid=1 instr=%h",
                     k, o_IMem_Req, o_Valid_Decode, o_Instr_Decode, mem_word(32'h0));
         end
         step();
      end
      i_Stall_Decode = 1'b0;
      @(negedge clk);
      tests++;
      if (o_IMem_Req !== 1'b1 || o_IMem_Addr !== 32'h8) begin
         fails++;
         $display("FAIL sd_resume: got req=%b addr=%h, required req=1 addr=00000008", o_IMem_Req, o_IMem_Addr);
      end
      step(); step(); step();
      i_Stall_Fetch = 1'b1;
      repeat (4) step();
      tests++;
      if (sb.size() != 0) begin fails++; $display("FAIL sd_drain: got %0d pending, required 0", sb.size()); end
   endtask

   task automatic test_wrap_align();
      do_reset();
      redirect_wb(32'hFFFF_FFFE);
      push_exp(32'hFFFF_FFFC, 32'h6);
      push_exp(32'h0, 32'hA);
      i_Stall_Fetch = 1'b0;
      @(negedge clk);
      tests++;
      if (o_IMem_Addr !== 32'hFFFF_FFFC) begin
         fails++;
         $display("FAIL wrap_align: got addr=%h, required fffffffc", o_IMem_Addr);
      end
      step();
      @(negedge clk);
      tests++;
      if (o_IMem_Addr !== 32'h0) begin
         fails++;
         $display("FAIL wrap_zero: got addr=%h, required 00000000", o_IMem_Addr);
      end
      step();
      i_Stall_Fetch = 1'b1;
      repeat (3) step();
      tests++;
      if (sb.size() != 0) begin fails++; $display("FAIL wrap_drain: got %0d pending, required 0", sb.size()); end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      redirect_wb(32'h40);
      push_exp(32'h40, 32'h48);
      i_Stall_Fetch = 1'b0;
      step();
      i_Stall_Decode = 1'b1; lat = 100;
      step(); step();
      @(negedge clk);
      tests++;
      if (o_IMem_Req !== 1'b1 || o_IMem_Addr !== 32'h44 || o_Instr_Decode !== mem_word(32'h40)) begin
         fails++;
         $display("FAIL rst_pre: got req=%b addr=%h instr=%h, required 1/00000044/%h", o_IMem_Req, o_IMem_Addr, o_Instr_Decode, mem_word(32'h40));
      end
      #1 rst_n = 1'b0;
      #1;
      tests++;
      if (o_IMem_Req !== 1'b0 || o_IMem_Addr !== 32'h0 || o_Valid_Decode !== 1'b0 ||
          o_Instr_Decode !== 32'h0 || o_PC_Plus_8_Decode !== 32'h8) begin
         fails++;
         $display("FAIL rst_async: got req=%b addr=%h valid=%b instr=%h pc8=%h, required 0/0/0/0/8",
                  o_IMem_Req, o_IMem_Addr, o_Valid_Decode, o_Instr_Decode, o_PC_Plus_8_Decode);
      end
      tests++;
      if (sb.size() != 0) begin fails++; $display("FAIL rst_drain: got %0d pending, required 0", sb.size()); end
   endtask

   task automatic test_sclr_mid_wait();
      do_reset();
      redirect_wb(32'h30);
      lat = 100; i_Stall_Fetch = 1'b0;
      step(); step();
      sclr = 1'b1;
      step();
      sclr = 1'b0;
      @(negedge clk);
      tests++;
      if (o_IMem_Req !== 1'b1 || o_IMem_Addr !== 32'h30 || o_Valid_Decode !== 1'b0 || o_PC_Plus_8_Decode !== 32'h8) begin
         fails++;
         $display("FAIL sclr_discard: got req=%b addr=%h valid=%b pc8=%h, required 1/00000030/0/00000008",
                  o_IMem_Req, o_IMem_Addr, o_Valid_Decode, o_PC_Plus_8_Decode);
      end
      lat = 0;
      push_exp(32'h0, 32'h8);
      step();
      @(negedge clk);
      tests++;
      if (o_IMem_Req !== 1'b1 || o_IMem_Addr !== 32'h0) begin
         fails++;
         $display("FAIL sclr_first: got req=%b addr=%h, required req=1 addr=00000000", o_IMem_Req, o_IMem_Addr);
      end
      step();
      i_Stall_Fetch = 1'b1;
      repeat (3) step();
      tests++;
      if (sb.size() != 0) begin fails++; $display("FAIL sclr_drain: got %0d pending, required 0", sb.size()); end
   endtask

   initial begin
      do_reset();
      rst_n = 1'b0;
      fork run_monitor(); join_none
      test_reset();
      test_zero_wait();
      test_wait();
      test_branch_while_wait();
      test_branch_and_wb();
      test_stall_decode();
      test_wrap_align();
      test_reset_mid_wait();
      test_sclr_mid_wait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
